vga_vram_arbiter: RTL and testbench

Shares one single-port synchronous video RAM between the VGA scan-out fetch path of `vgacontroller` and a host write/read port. Display fetches have absolute priority so scan-out never stalls. Host accesses are served in idle cycles through a req/ack handshake, and a wait counter flags host starvation. The block sits between the pixel-fetch logic of `vgacontroller` and the VRAM instance.

---
 rtl/vga_vram_arbiter.sv | 116 +++++++++++
 tb/tb_vga_vram_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out fetches always win, host
// accesses use idle slots through a req/ack handshake with a starvation flag.
module vga_vram_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int DATA_W     = 8,
   parameter int STARVE_LIM = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_starved,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [7:0] LIM = 8'(STARVE_LIM);

   typedef enum logic {H_IDLE, H_ACK} host_state_t;

   host_state_t       state_reg, state_next;
   logic              grant_disp, grant_host;
   logic [7:0]        wait_cnt_reg, wait_cnt_next;
   logic              starved_reg, starved_next;
   logic              ram_en_reg, ram_we_reg;
   logic [ADDR_W-1:0] ram_addr_reg;
   logic [DATA_W-1:0] ram_wdata_reg;
   logic              tag_disp_reg, tag_host_reg;
   logic              disp_valid_reg, host_rvalid_reg;
   logic [DATA_W-1:0] disp_hold_reg, host_hold_reg;

   always_comb begin
      grant_disp    = disp_req;
      grant_host    = !disp_req && (state_reg == H_IDLE) && host_req;
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      starved_next  = starved_reg;

      case (state_reg)
         H_IDLE:  if (grant_host) state_next = H_ACK;
         default: state_next = H_IDLE;
      endcase

      // Only waits lost to the display count; the H_ACK cycle simply holds.
      if (grant_host || !host_req)
         wait_cnt_next = 8'd0;
      else if ((state_reg == H_IDLE) && disp_req && (wait_cnt_reg != 8'hFF))
         wait_cnt_next = wait_cnt_reg + 8'd1;

      if (grant_host)
         starved_next = 1'b0;
      else if (wait_cnt_next >= LIM)
         starved_next = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= H_IDLE;
         wait_cnt_reg    <= 8'd0;
         starved_reg     <= 1'b0;
         ram_en_reg      <= 1'b0;
         ram_we_reg      <= 1'b0;
         ram_addr_reg    <= '0;
         ram_wdata_reg   <= '0;
         tag_disp_reg    <= 1'b0;
         tag_host_reg    <= 1'b0;
         disp_valid_reg  <= 1'b0;
         host_rvalid_reg <= 1'b0;
         disp_hold_reg   <= '0;
         host_hold_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         starved_reg  <= starved_next;
         ram_en_reg   <= grant_disp || grant_host;
         ram_we_reg   <= grant_host && host_we;
         if (grant_disp)
            ram_addr_reg <= disp_addr;
         else if (grant_host) begin
            ram_addr_reg  <= host_addr;
            ram_wdata_reg <= host_wdata;
         end
         // Tags ride with the command cycle, valids with the data cycle.
         tag_disp_reg    <= grant_disp;
         tag_host_reg    <= grant_host && !host_we;
         disp_valid_reg  <= tag_disp_reg;
         host_rvalid_reg <= tag_host_reg;
         if (disp_valid_reg)  disp_hold_reg <= ram_rdata;
         if (host_rvalid_reg) host_hold_reg <= ram_rdata;
      end
   end

   assign ram_en       = ram_en_reg;
   assign ram_we       = ram_we_reg;
   assign ram_addr     = ram_addr_reg;
   assign ram_wdata    = ram_wdata_reg;
   assign host_ack     = (state_reg == H_ACK);
   assign host_starved = starved_reg;
   assign disp_valid   = disp_valid_reg;
   assign host_rvalid  = host_rvalid_reg;
   assign disp_data    = disp_valid_reg  ? ram_rdata : disp_hold_reg;
   assign host_rdata   = host_rvalid_reg ? ram_rdata : host_hold_reg;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural single-port VRAM
// preloaded so that each location reads back (addr+1) until written.
module tb_vga_vram_arbiter;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_valid;
   logic [DATA_W-1:0] disp_data;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;
   logic              host_starved;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata = '0;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(64)) dut (
      .clk(clk), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_valid(disp_valid), .disp_data(disp_data),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .host_starved(host_starved),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else
         $display("ok   %s: 0x%0h", tag, got);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i + 1);
      reset = 1'b0; disp_req = 0; disp_addr = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      #20 reset = 1'b1;
      #1;
      check("rst_ram_en",    32'(ram_en), 0);
      check("rst_ram_we",    32'(ram_we), 0);
      check("rst_ram_addr",  32'(ram_addr), 0);
      check("rst_ram_wdata", 32'(ram_wdata), 0);
      check("rst_host_ack",  32'(host_ack), 0);
      check("rst_starved",   32'(host_starved), 0);
      check("rst_disp_vld",  32'(disp_valid), 0);
      check("rst_host_rvld", 32'(host_rvalid), 0);
      check("rst_disp_data", 32'(disp_data), 0);
      check("rst_host_rdat", 32'(host_rdata), 0);

      // Display burst 0x10..0x13, data comes back as addr+1 two cycles later.
      disp_req = 1;
      for (int i = 0; i < 4; i++) begin
         disp_addr = ADDR_W'(16 + i);
         tick();
         check("disp_ram_en",   32'(ram_en), 1);
         check("disp_ram_we",   32'(ram_we), 0);
         check("disp_ram_addr", 32'(ram_addr), 32'(16 + i));
         check("disp_valid",    32'(disp_valid), (i == 0) ? 0 : 1);
         if (i > 0) check("disp_data", 32'(disp_data), 32'(16 + i));
      end
      disp_req = 0;
      tick();
      check("disp_valid_last", 32'(disp_valid), 1);
      check("disp_data_last",  32'(disp_data), 32'h14);
      check("disp_idle_en",    32'(ram_en), 0);
      tick();
      check("disp_valid_end",  32'(disp_valid), 0);
      check("disp_data_hold",  32'(disp_data), 32'h14);

      // Host write then host read of 0x0200.
      host_req = 1; host_we = 1; host_addr = 14'h0200; host_wdata = 8'hA5;
      tick();
      check("hw_ack",   32'(host_ack), 1);
      check("hw_en",    32'(ram_en), 1);
      check("hw_we",    32'(ram_we), 1);
      check("hw_addr",  32'(ram_addr), 32'h200);
      check("hw_wdata", 32'(ram_wdata), 32'hA5);
      host_req = 0;
      tick();
      check("hw_ack_off", 32'(host_ack), 0);
      check("hw_rvalid",  32'(host_rvalid), 0);
      host_req = 1; host_we = 0; host_wdata = 8'h00;
      tick();
      check("hr_ack", 32'(host_ack), 1);
      check("hr_en",  32'(ram_en), 1);
      check("hr_we",  32'(ram_we), 0);
      host_req = 0;
      tick();
      check("hr_rvalid", 32'(host_rvalid), 1);
      check("hr_rdata",  32'(host_rdata), 32'hA5);
      check("hr_no_dv",  32'(disp_valid), 0);
      tick();
      check("hr_rvalid_off", 32'(host_rvalid), 0);
      check("hr_rdata_hold", 32'(host_rdata), 32'hA5);

      // Contention: display holds the RAM for 70 cycles.
      host_req = 1; host_we = 1; host_addr = 14'h0300; host_wdata = 8'h3C;
      disp_req = 1; disp_addr = 14'h0040;
      for (int i = 1; i <= 70; i++) begin
         tick();
         check("cont_no_ack", 32'(host_ack), 0);
         if (i == 63) check("starved_63", 32'(host_starved), 0);
         if (i == 64) check("starved_64", 32'(host_starved), 1);
      end
      check("starved_70", 32'(host_starved), 1);
      disp_req = 0;
      tick();
      check("cont_ack",     32'(host_ack), 1);
      check("cont_starved", 32'(host_starved), 0);
      check("cont_we",      32'(ram_we), 1);
      check("cont_addr",    32'(ram_addr), 32'h300);
      // Request still held: H_ACK cycle issues nothing, then re-grants.
      tick();
      check("hold_ack_off", 32'(host_ack), 0);
      check("hold_no_en",   32'(ram_en), 0);
      tick();
      check("hold_reack",   32'(host_ack), 1);
      check("hold_reen",    32'(ram_en), 1);
      host_req = 0;
      tick();
      check("hold_end_ack", 32'(host_ack), 0);
      check("hold_end_en",  32'(ram_en), 0);

      // Build 62 waits, then reset while a display read is in flight.
      host_req = 1; disp_req = 1; disp_addr = 14'h0020;
      repeat (62) tick();
      check("pre_rst_en", 32'(ram_en), 1);
      reset = 1'b0;
      #1;
      check("async_rst_en", 32'(ram_en), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("post_rst_dv", 32'(disp_valid), 0);
      repeat (4) tick();
      check("post_rst_starved", 32'(host_starved), 0);
      check("post_rst_no_ack",  32'(host_ack), 0);
      disp_req = 0;
      tick();
      check("post_rst_ack", 32'(host_ack), 1);
      host_req = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
